ctrl_pipe_unit: RTL and testbench

- Parametrised successor to the single-cycle instruction-class decoder.
- Decodes a 32-bit ARM-style instruction in ID, then carries the decoded control bundle through N_STAGES registered pipeline stages (EX, MEM, WB, ...).
- Supports global stall, branch flush and load-use hazard bubble insertion.
- Sits between the fetch/IF-ID register and the datapath stage registers.

---
 rtl/ctrl_pipe_pkg.sv | 64 ++++++
 rtl/ctrl_pipe_unit_if.sv | 53 +++++
 rtl/ctrl_decode.sv | 52 +++++
 rtl/ctrl_pipe_unit.sv | 125 ++++++++++++
 tb/tb_ctrl_pipe_unit.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pipe_pkg.sv
// ctrl_pipe_pkg: shared types and constants for the control pipeline.
//   - instruction class codes (instr[27:25])
//   - ALU opcode constants used by load/store and branch decode
//   - ctrl_t: the control bundle carried from ID down the stage registers
//   - cond_e / cond_pass: ARM condition codes, used when CTRL_PIPE_COND_EXEC_EN
//     is defined
package ctrl_pipe_pkg;

  // Container width for the alu_op and rd fields of the bundle. The top
  // slices these down to ALU_OP_W / REG_ADDR_W, so both must stay <= 8.
  localparam int CTRL_FIELD_W = 8;

  localparam logic [2:0] CLS_DP_SHIFT = 3'b000;
  localparam logic [2:0] CLS_DP_IMM   = 3'b001;
  localparam logic [2:0] CLS_LS_IMM   = 3'b010;
  localparam logic [2:0] CLS_LS_REG   = 3'b011;
  localparam logic [2:0] CLS_BRANCH   = 3'b101;

  localparam logic [3:0] ALU_ADD = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0010;

  typedef struct packed {
    logic                    valid;
    logic                    b;
    logic                    load;
    logic                    rf;
    logic                    shift;
    logic [CTRL_FIELD_W-1:0] alu_op;
    logic [CTRL_FIELD_W-1:0] rd;
  } ctrl_t;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_e;

  // nzcv = {N, Z, C, V}. NV (1111) is treated as never-execute.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v, res;
    {n, z, c, v} = nzcv;
    case (cond)
      COND_EQ: res = z;
      COND_NE: res = !z;
      COND_CS: res = c;
      COND_CC: res = !c;
      COND_MI: res = n;
      COND_PL: res = !n;
      COND_VS: res = v;
      COND_VC: res = !v;
      COND_HI: res = c && !z;
      COND_LS: res = !c || z;
      COND_GE: res = (n == v);
      COND_LT: res = (n != v);
      COND_GT: res = !z && (n == v);
      COND_LE: res = z || (n != v);
      COND_AL: res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ctrl_pipe_unit_if.sv
// ctrl_pipe_if: bundle between the IF/ID side and the control pipeline.
//   master: drives instr_valid, instr, stall, flush, flags
//   slave : drives instr_ready, id_* decode, hazard_stall, st_* stage outputs
//           (and cond_fail when CTRL_PIPE_COND_EXEC_EN is defined)
interface ctrl_pipe_if #(
  parameter int INSTR_W    = 32,
  parameter int ALU_OP_W   = 4,
  parameter int N_STAGES   = 3,
  parameter int REG_ADDR_W = 4
);
  logic                           instr_valid;
  logic [INSTR_W-1:0]             instr;
  logic                           instr_ready;
  logic                           stall;
  logic                           flush;
  logic [3:0]                     flags;
  logic                           id_b_instr;
  logic                           id_load_instr;
  logic                           id_rf_instr;
  logic                           id_shift_imm;
  logic [ALU_OP_W-1:0]            id_alu_op;
  logic                           hazard_stall;
  logic [N_STAGES-1:0]            st_valid;
  logic [N_STAGES-1:0]            st_b;
  logic [N_STAGES-1:0]            st_load;
  logic [N_STAGES-1:0]            st_rf;
  logic [N_STAGES-1:0]            st_shift;
  logic [N_STAGES*ALU_OP_W-1:0]   st_alu_op;
  logic [N_STAGES*REG_ADDR_W-1:0] st_rd;
`ifdef CTRL_PIPE_COND_EXEC_EN
  logic                           cond_fail;
`endif

  modport master (
    output instr_valid, instr, stall, flush, flags,
`ifdef CTRL_PIPE_COND_EXEC_EN
    input  cond_fail,
`endif
    input  instr_ready, id_b_instr, id_load_instr, id_rf_instr, id_shift_imm,
           id_alu_op, hazard_stall, st_valid, st_b, st_load, st_rf, st_shift,
           st_alu_op, st_rd
  );

  modport slave (
    input  instr_valid, instr, stall, flush, flags,
`ifdef CTRL_PIPE_COND_EXEC_EN
    output cond_fail,
`endif
    output instr_ready, id_b_instr, id_load_instr, id_rf_instr, id_shift_imm,
           id_alu_op, hazard_stall, st_valid, st_b, st_load, st_rf, st_shift,
           st_alu_op, st_rd
  );
endinterface

// File: rtl/ctrl_decode.sv
// ctrl_decode: purely combinational instruction -> control bundle decode.
//   instr_i   : instruction held in ID
//   ctrl_o    : decoded bundle; valid=0 and all fields zero for bubble classes
//   rm_used_o : instruction class reads rm (instr[3:0]) as a register
module ctrl_decode
  import ctrl_pipe_pkg::*;
#(
  parameter int INSTR_W  = 32,
  parameter int ALU_OP_W = 4
) (
  input  logic [INSTR_W-1:0] instr_i,
  output ctrl_t              ctrl_o,
  output logic               rm_used_o
);

  logic [2:0] cls;
  logic       unused_instr;

  assign cls          = instr_i[27:25];
  // Only a subset of instruction bits is decoded here.
  assign unused_instr = ^instr_i;

  always_comb begin
    ctrl_o    = '0;
    rm_used_o = (cls == CLS_DP_SHIFT) || (cls == CLS_LS_REG);
    case (cls)
      CLS_DP_SHIFT, CLS_DP_IMM: begin
        ctrl_o.valid                  = 1'b1;
        ctrl_o.rf                     = 1'b1;
        ctrl_o.shift                  = instr_i[20];
        ctrl_o.alu_op[ALU_OP_W-1:0]   = instr_i[21 +: ALU_OP_W];
        ctrl_o.rd                     = CTRL_FIELD_W'(instr_i[15:12]);
      end
      CLS_LS_IMM, CLS_LS_REG: begin
        ctrl_o.valid  = 1'b1;
        ctrl_o.rf     = 1'b1;
        ctrl_o.load   = instr_i[20];
        // U bit selects address offset direction.
        ctrl_o.alu_op = instr_i[23] ? CTRL_FIELD_W'(ALU_ADD) : CTRL_FIELD_W'(ALU_SUB);
        ctrl_o.rd     = CTRL_FIELD_W'(instr_i[15:12]);
      end
      CLS_BRANCH: begin
        ctrl_o.valid  = 1'b1;
        ctrl_o.b      = 1'b1;
        ctrl_o.alu_op = CTRL_FIELD_W'(ALU_ADD);
        ctrl_o.rd     = CTRL_FIELD_W'(instr_i[15:12]);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ctrl_pipe_unit.sv
// ctrl_pipe_unit: ID decode plus N_STAGES registered control stages
// (stage 0 = EX) with global stall, branch flush and load-use bubbles.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high; clears every stage immediately
//   bus   : ctrl_pipe_if.slave (instruction handshake, decode, stage outputs)
// Optional: CTRL_PIPE_COND_EXEC_EN adds ARM condition evaluation against
// bus.flags and the registered bus.cond_fail output.
module ctrl_pipe_unit
  import ctrl_pipe_pkg::*;
#(
  parameter int INSTR_W    = 32,
  parameter int ALU_OP_W   = 4,
  parameter int N_STAGES   = 3,
  parameter int REG_ADDR_W = 4
) (
  input  logic      clk,
  input  logic      reset,
  ctrl_pipe_if.slave bus
);

  ctrl_t                          id_dec;
  logic                           rm_used;
  logic                           cond_ok;
  logic                           ld_hit;
  logic                           hazard;
  logic                           take_id;
  logic                           load_id;
  logic [CTRL_FIELD_W-1:0]        id_rn;
  logic [CTRL_FIELD_W-1:0]        id_rm;
  ctrl_t [N_STAGES-1:0]           st_q;
  ctrl_t [N_STAGES-1:0]           st_d;
  logic [N_STAGES-1:0]            vld_v, b_v, load_v, rf_v, shift_v;
  logic [N_STAGES*ALU_OP_W-1:0]   alu_v;
  logic [N_STAGES*REG_ADDR_W-1:0] rd_v;
  logic                           unused_top;

  ctrl_decode #(
    .INSTR_W  (INSTR_W),
    .ALU_OP_W (ALU_OP_W)
  ) u_decode (
    .instr_i   (bus.instr),
    .ctrl_o    (id_dec),
    .rm_used_o (rm_used)
  );

`ifdef CTRL_PIPE_COND_EXEC_EN
  logic cond_fail_q;
  assign cond_ok       = cond_pass(bus.instr[31:28], bus.flags);
  assign bus.cond_fail = cond_fail_q;
`else
  assign cond_ok = 1'b1;
`endif

  assign bus.id_b_instr    = id_dec.b;
  assign bus.id_load_instr = id_dec.load;
  assign bus.id_rf_instr   = id_dec.rf;
  assign bus.id_shift_imm  = id_dec.shift;
  assign bus.id_alu_op     = id_dec.alu_op[ALU_OP_W-1:0];

  // Load-use: the load sitting in EX writes a register the ID instruction reads.
  assign id_rn  = CTRL_FIELD_W'(bus.instr[19:16]);
  assign id_rm  = CTRL_FIELD_W'(bus.instr[3:0]);
  assign ld_hit = st_q[0].valid && st_q[0].load &&
                  ((st_q[0].rd == id_rn) || (rm_used && (st_q[0].rd == id_rm)));
  assign hazard = bus.instr_valid && ld_hit && !bus.stall && !bus.flush;
  assign take_id = bus.instr_valid && !bus.stall && !hazard && !bus.flush;
  // A condition-failed instruction is still consumed, but enters as a bubble.
  assign load_id = take_id && cond_ok && id_dec.valid;

  assign bus.hazard_stall = hazard;
  assign bus.instr_ready  = take_id;

  always_comb begin
    st_d    = '0;
    st_d[0] = load_id ? id_dec : '0;
    for (int k = 1; k < N_STAGES; k++) begin
      st_d[k] = st_q[k-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q <= '0;
`ifdef CTRL_PIPE_COND_EXEC_EN
      cond_fail_q <= 1'b0;
`endif
    end else if (!bus.stall) begin
      st_q <= st_d;
`ifdef CTRL_PIPE_COND_EXEC_EN
      cond_fail_q <= take_id && !cond_ok;
`endif
    end
  end

  always_comb begin
    vld_v   = '0;
    b_v     = '0;
    load_v  = '0;
    rf_v    = '0;
    shift_v = '0;
    alu_v   = '0;
    rd_v    = '0;
    for (int k = 0; k < N_STAGES; k++) begin
      vld_v[k]                       = st_q[k].valid;
      b_v[k]                         = st_q[k].b;
      load_v[k]                      = st_q[k].load;
      rf_v[k]                        = st_q[k].rf;
      shift_v[k]                     = st_q[k].shift;
      alu_v[k*ALU_OP_W +: ALU_OP_W]  = st_q[k].alu_op[ALU_OP_W-1:0];
      rd_v[k*REG_ADDR_W +: REG_ADDR_W] = st_q[k].rd[REG_ADDR_W-1:0];
    end
  end

  assign bus.st_valid  = vld_v;
  assign bus.st_b      = b_v;
  assign bus.st_load   = load_v;
  assign bus.st_rf     = rf_v;
  assign bus.st_shift  = shift_v;
  assign bus.st_alu_op = alu_v;
  assign bus.st_rd     = rd_v;

  // Upper container bits and unused instruction/flag bits.
  assign unused_top = ^{bus.instr, bus.flags, st_q};

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
module tb_ctrl_pipe_unit;

  localparam int INSTR_W    = 32;
  localparam int ALU_OP_W   = 4;
  localparam int N_STAGES   = 3;
  localparam int REG_ADDR_W = 4;

  localparam int S_VALID = 0,  S_B = 1,  S_LOAD = 2,  S_RF = 3,  S_SHIFT = 4;
  localparam int S_ALU   = 5,  S_RD = 6, S_HAZ = 7,   S_READY = 8;
  localparam int I_ALU   = 9,  I_RF = 10, I_LOAD = 11, I_B = 12, I_SHIFT = 13;
  localparam int S_CF    = 14;

  localparam logic [31:0] ADD1  = 32'hE2811005;
  localparam logic [31:0] LDR   = 32'hE5912000;
  localparam logic [31:0] ADD2  = 32'hE0823003;
  localparam logic [31:0] ADDI3 = 32'hE2813002;
  localparam logic [31:0] ADDR  = 32'hE0813002;
  localparam logic [31:0] BR    = 32'hEA000004;
  localparam logic [31:0] LDRS  = 32'hE5112000;
  localparam logic [31:0] ADDS  = 32'hE0914005;
  localparam logic [31:0] C111  = 32'hEE012345;

  typedef struct {
    int          code;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic clk;
  logic reset;
  exp_t sb_q[$];
  exp_t mon_e;
  logic [31:0] mon_act;
  int n_cmp;
  int n_err;

  ctrl_pipe_if #(
    .INSTR_W(INSTR_W), .ALU_OP_W(ALU_OP_W), .N_STAGES(N_STAGES), .REG_ADDR_W(REG_ADDR_W)
  ) pif ();

  ctrl_pipe_unit #(
    .INSTR_W(INSTR_W), .ALU_OP_W(ALU_OP_W), .N_STAGES(N_STAGES), .REG_ADDR_W(REG_ADDR_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (pif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] get_sig(input int code);
    case (code)
      S_VALID: return 32'(pif.st_valid);
      S_B:     return 32'(pif.st_b);
      S_LOAD:  return 32'(pif.st_load);
      S_RF:    return 32'(pif.st_rf);
      S_SHIFT: return 32'(pif.st_shift);
      S_ALU:   return 32'(pif.st_alu_op);
      S_RD:    return 32'(pif.st_rd);
      S_HAZ:   return 32'(pif.hazard_stall);
      S_READY: return 32'(pif.instr_ready);
      I_ALU:   return 32'(pif.id_alu_op);
      I_RF:    return 32'(pif.id_rf_instr);
      I_LOAD:  return 32'(pif.id_load_instr);
      I_B:     return 32'(pif.id_b_instr);
      I_SHIFT: return 32'(pif.id_shift_imm);
`ifdef CTRL_PIPE_COND_EXEC_EN
      S_CF:    return 32'(pif.cond_fail);
`endif
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic chk(input int code, input logic [31:0] val, input string name);
    exp_t e;
    e.code = code;
    e.val  = val;
    e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins);
    pif.instr_valid = v;
    pif.instr       = ins;
  endtask

  task automatic drain();
    drive(1'b0, 32'h0);
    repeat (3) cyc();
  endtask

  // Monitor: consumes every pending expectation on the falling edge.
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      mon_e   = sb_q.pop_front();
      mon_act = get_sig(mon_e.code);
      n_cmp++;
      if (mon_act !== mon_e.val) begin
        n_err++;
        $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", mon_e.name, mon_act, mon_e.val, $time);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    pif.instr_valid = 1'b0;
    pif.instr       = '0;
    pif.stall       = 1'b0;
    pif.flush       = 1'b0;
    pif.flags       = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // reset state
    chk(S_VALID, 0, "rst_valid"); chk(S_RD, 0, "rst_rd"); chk(S_ALU, 0, "rst_alu");
    chk(S_HAZ, 0, "rst_haz"); chk(S_READY, 0, "rst_ready");
    cyc();

    // ADD-imm stream through all stages
    drive(1'b1, ADD1);
    chk(I_ALU, 4, "add_id_alu"); chk(I_RF, 1, "add_id_rf"); chk(I_LOAD, 0, "add_id_load");
    chk(I_B, 0, "add_id_b"); chk(I_SHIFT, 0, "add_id_shift");
    chk(S_READY, 1, "add_ready"); chk(S_HAZ, 0, "add_haz"); chk(S_VALID, 0, "add_v0");
    cyc();
    chk(S_VALID, 3'b001, "add_v1"); chk(S_RD, 12'h001, "add_rd1");
    chk(S_ALU, 12'h004, "add_alu1"); chk(S_RF, 3'b001, "add_rf1");
    cyc();
    chk(S_VALID, 3'b011, "add_v2"); chk(S_RD, 12'h011, "add_rd2");
    cyc();
    drive(1'b0, ADD1);
    chk(S_VALID, 3'b111, "add_v3"); chk(S_RD, 12'h111, "add_rd3");
    chk(S_ALU, 12'h444, "add_alu3"); chk(S_RF, 3'b111, "add_rf3"); chk(S_READY, 0, "idle_ready");
    cyc();
    chk(S_VALID, 3'b110, "add_v4"); chk(S_RD, 12'h110, "add_rd4");
    chk(S_ALU, 12'h440, "add_alu4"); chk(S_RF, 3'b110, "add_rf4");
    cyc();
    chk(S_VALID, 3'b100, "add_v5"); chk(S_RD, 12'h100, "add_rd5");
    cyc();

    // load-use on rn
    drive(1'b1, LDR);
    chk(I_LOAD, 1, "ldr_id_load"); chk(I_ALU, 4, "ldr_id_alu"); chk(I_RF, 1, "ldr_id_rf");
    chk(S_HAZ, 0, "ldr_haz"); chk(S_READY, 1, "ldr_ready"); chk(S_VALID, 0, "ldr_v0");
    cyc();
    drive(1'b1, ADD2);
    chk(S_HAZ, 1, "lu_haz"); chk(S_READY, 0, "lu_ready"); chk(S_VALID, 3'b001, "lu_v1");
    chk(S_LOAD, 3'b001, "lu_ld1"); chk(S_RD, 12'h002, "lu_rd1");
    cyc();
    chk(S_HAZ, 0, "lu_haz2"); chk(S_READY, 1, "lu_ready2"); chk(S_VALID, 3'b010, "lu_bubble");
    chk(S_LOAD, 3'b010, "lu_ld2"); chk(S_RD, 12'h020, "lu_rd2");
    cyc();
    drive(1'b0, ADD2);
    chk(S_VALID, 3'b101, "lu_v3"); chk(S_RD, 12'h203, "lu_rd3");
    chk(S_ALU, 12'h404, "lu_alu3"); chk(S_LOAD, 3'b100, "lu_ld3"); chk(S_RF, 3'b101, "lu_rf3");
    cyc();
    chk(S_VALID, 3'b010, "lu_v4"); chk(S_RD, 12'h030, "lu_rd4");
    cyc();
    chk(S_VALID, 3'b100, "lu_v5"); chk(S_RD, 12'h300, "lu_rd5");
    cyc();

    // rm only counts for classes that read it
    drive(1'b1, LDR);
    chk(S_HAZ, 0, "rm_ldr_haz");
    cyc();
    drive(1'b1, ADDI3);
    chk(S_HAZ, 0, "rm_unused_haz"); chk(S_READY, 1, "rm_unused_ready");
    cyc();
    drive(1'b1, LDR);
    chk(S_HAZ, 0, "rm_ldr2_haz"); chk(S_READY, 1, "rm_ldr2_ready");
    cyc();
    drive(1'b1, ADDR);
    chk(S_HAZ, 1, "rm_haz"); chk(S_READY, 0, "rm_ready");
    chk(S_VALID, 3'b111, "rm_v"); chk(S_LOAD, 3'b101, "rm_ld");
    cyc();
    chk(S_HAZ, 0, "rm_haz2"); chk(S_READY, 1, "rm_ready2");
    chk(S_VALID, 3'b110, "rm_v2"); chk(S_LOAD, 3'b010, "rm_ld2");
    cyc();
    drain();

    // branch then flush
    drive(1'b1, BR);
    chk(I_B, 1, "br_id_b"); chk(I_RF, 0, "br_id_rf"); chk(I_ALU, 4, "br_id_alu");
    chk(S_READY, 1, "br_ready"); chk(S_VALID, 0, "br_v0");
    cyc();
    drive(1'b1, ADD1);
    pif.flush = 1'b1;
    chk(S_READY, 0, "fl_ready"); chk(S_HAZ, 0, "fl_haz");
    chk(S_VALID, 3'b001, "fl_v1"); chk(S_B, 3'b001, "fl_b1");
    cyc();
    pif.flush = 1'b0;
    chk(S_READY, 1, "fl_ready2"); chk(S_VALID, 3'b010, "fl_bubble"); chk(S_B, 3'b010, "fl_b2");
    cyc();
    drive(1'b0, ADD1);
    chk(S_VALID, 3'b101, "fl_v3"); chk(S_B, 3'b100, "fl_b3"); chk(S_RD, 12'h001, "fl_rd3");
    cyc();
    drain();

    // stall with a full pipe
    drive(1'b1, LDRS);
    chk(I_ALU, 2, "ldrs_id_alu"); chk(I_LOAD, 1, "ldrs_id_load");
    cyc();
    drive(1'b1, ADD1);
    chk(S_HAZ, 0, "st_fill_haz");
    cyc();
    drive(1'b1, ADDS);
    chk(I_SHIFT, 1, "adds_id_shift"); chk(I_ALU, 4, "adds_id_alu");
    cyc();
    drive(1'b1, ADD2);
    pif.stall = 1'b1;
    chk(S_VALID, 3'b111, "stl_v1"); chk(S_RD, 12'h214, "stl_rd1"); chk(S_ALU, 12'h244, "stl_alu1");
    chk(S_SHIFT, 3'b001, "stl_sh1"); chk(S_LOAD, 3'b100, "stl_ld1");
    chk(S_READY, 0, "stl_ready"); chk(S_HAZ, 0, "stl_haz");
    cyc();
    chk(S_VALID, 3'b111, "stl_v2"); chk(S_RD, 12'h214, "stl_rd2"); chk(S_ALU, 12'h244, "stl_alu2");
    cyc();
    chk(S_RD, 12'h214, "stl_rd3"); chk(S_SHIFT, 3'b001, "stl_sh3");
    cyc();
    pif.stall = 1'b0;
    chk(S_RD, 12'h214, "stl_rd4"); chk(S_VALID, 3'b111, "stl_v4"); chk(S_READY, 1, "stl_rel_ready");
    cyc();
    drive(1'b0, ADD2);
    chk(S_VALID, 3'b111, "rel_v1"); chk(S_RD, 12'h143, "rel_rd1");
    chk(S_SHIFT, 3'b010, "rel_sh1"); chk(S_LOAD, 3'b000, "rel_ld1"); chk(S_ALU, 12'h444, "rel_alu1");
    cyc();
    chk(S_VALID, 3'b110, "rel_v2"); chk(S_RD, 12'h430, "rel_rd2"); chk(S_SHIFT, 3'b100, "rel_sh2");
    cyc();
    drain();

    // class 111 is consumed as a zero bubble
    drive(1'b1, C111);
    chk(S_READY, 1, "c7_ready"); chk(I_RF, 0, "c7_id_rf"); chk(I_ALU, 0, "c7_id_alu");
    chk(I_B, 0, "c7_id_b"); chk(I_LOAD, 0, "c7_id_load"); chk(I_SHIFT, 0, "c7_id_shift");
    cyc();
    drive(1'b0, C111);
    chk(S_VALID, 0, "c7_v"); chk(S_RD, 0, "c7_rd"); chk(S_ALU, 0, "c7_alu"); chk(S_RF, 0, "c7_rf");
    cyc();

    // asynchronous reset between edges
    drive(1'b1, ADD1);
    chk(S_READY, 1, "ar_ready");
    cyc();
    cyc();
    drive(1'b0, ADD1);
    chk(S_VALID, 3'b011, "ar_pre_v");
    cyc();
    #2;
    reset = 1'b1;
    chk(S_VALID, 0, "ar_valid"); chk(S_RD, 0, "ar_rd"); chk(S_ALU, 0, "ar_alu"); chk(S_RF, 0, "ar_rf");
    cyc();
    reset = 1'b0;
    chk(S_VALID, 0, "ar_post_v");
    cyc();

`ifdef CTRL_PIPE_COND_EXEC_EN
    // EQ with Z=0 fails, EQ with Z=1 passes
    pif.flags = 4'b0000;
    drive(1'b1, 32'h02811005);
    chk(S_READY, 1, "ce_ready"); chk(S_HAZ, 0, "ce_haz");
    cyc();
    pif.flags = 4'b0100;
    chk(S_VALID, 0, "ce_fail_v"); chk(S_CF, 1, "ce_fail_cf"); chk(S_RD, 0, "ce_fail_rd");
    cyc();
    drive(1'b0, 32'h02811005);
    chk(S_VALID, 3'b001, "ce_pass_v"); chk(S_CF, 0, "ce_pass_cf"); chk(S_RD, 12'h001, "ce_pass_rd");
    cyc();
`endif

    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL sb_drain: %0d expectations left, expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
